countdown_timer: RTL and testbench

- Hours:minutes:seconds countdown timer; the down-counting counterpart to the team's up-counting time-of-day clock.
- Takes a loaded time, decrements it once per internal one-second tick, and pulses `done` when it reaches 00:00:00.
- Provides start/stop/pause control and input-range checking. Sits beside the clock block and feeds alarm or display logic.

---
 rtl/countdown_timer.sv | 128 ++++++++++++
 tb/tb_countdown_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//   Hours:minutes:seconds countdown timer. A loaded time is decremented once
//   per internal one-second tick, derived from a TICK_DIV-cycle prescaler.
//   done pulses for one cycle when the count reaches 00:00:00.
//
// Parameters
//   TICK_DIV  clk cycles per one-second tick (minimum 2)
//   DIV_W     prescaler width, 2**DIV_W >= TICK_DIV
//
// Ports
//   clk       system clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   load      one-cycle request to load load_hr/min/sec
//   load_hr   hours to load (0..23)
//   load_min  minutes to load (0..59)
//   load_sec  seconds to load (0..59)
//   start     begin or resume counting
//   stop      pause counting
//   hr        current hours
//   min       current minutes
//   sec       current seconds
//   running   high while counting
//   done      one-cycle pulse on expiry
//   load_err  one-cycle pulse when a load is rejected
module countdown_timer #(
  parameter int TICK_DIV = 1000,
  parameter int DIV_W    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] load_hr,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] presc;

  logic load_ok;
  logic time_zero;
  logic tick;
  logic last_sec;

  assign load_ok   = (load_hr <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
  assign time_zero = (hr == 5'd0) && (min == 6'd0) && (sec == 6'd0);
  assign tick      = (state == RUN) && (presc == DIV_W'(TICK_DIV - 1));
  // The decrement on this tick lands on 00:00:00.
  assign last_sec  = (hr == 5'd0) && (min == 6'd0) && (sec <= 6'd1);

  // running is a pure decode of the state register, so it is glitch-free
  // and changes only on the clock edge.
  assign running = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      hr       <= '0;
      min      <= '0;
      sec      <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;

      if (load) begin
        // A load (valid or not) suppresses stop/start and any tick this cycle.
        if (load_ok) begin
          hr    <= load_hr;
          min   <= load_min;
          sec   <= load_sec;
          presc <= '0;
          state <= IDLE;
        end else begin
          load_err <= 1'b1;
        end
      end else if (state == RUN) begin
        if (tick) begin
          presc <= '0;
          if (sec != 6'd0) begin
            sec <= sec - 6'd1;
          end else if (min != 6'd0) begin
            min <= min - 6'd1;
            sec <= 6'd59;
          end else if (hr != 5'd0) begin
            hr  <= hr - 5'd1;
            min <= 6'd59;
            sec <= 6'd59;
          end
          // Expiry takes precedence over a simultaneous stop; otherwise the
          // decrement is applied and then the stop takes effect.
          if (last_sec) begin
            state <= EXPIRED;
            done  <= 1'b1;
          end else if (stop) begin
            state <= PAUSE;
          end
        end else begin
          presc <= presc + DIV_W'(1);
          if (stop) begin
            state <= PAUSE;
          end
        end
      end else if (!stop && start && !time_zero) begin
        // Outside RUN a stop only masks a simultaneous start.
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed test of countdown_timer with TICK_DIV=4. Inputs are driven and
//   outputs sampled 1 time unit after each rising edge.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;
  logic       done;
  logic       load_err;

  int errors = 0;
  int checks = 0;

  countdown_timer #(
    .TICK_DIV(4),
    .DIV_W   (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_hr (load_hr),
    .load_min(load_min),
    .load_sec(load_sec),
    .start   (start),
    .stop    (stop),
    .hr      (hr),
    .min     (min),
    .sec     (sec),
    .running (running),
    .done    (done),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hr"},  int'(hr),  h);
    check({tag, ".min"}, int'(min), m);
    check({tag, ".sec"}, int'(sec), s);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load     = 1'b1;
    load_hr  = 5'(h);
    load_min = 6'(m);
    load_sec = 6'(s);
    step();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    load_hr  = '0;
    load_min = '0;
    load_sec = '0;
    start    = 1'b0;
    stop     = 1'b0;

    // Reset state
    step();
    step();
    check_time("reset", 0, 0, 0);
    check("reset.running",  int'(running),  0);
    check("reset.done",     int'(done),     0);
    check("reset.load_err", int'(load_err), 0);
    rst_n = 1'b1;
    step();

    // 00:00:03 counts down at 4-cycle spacing and expires
    do_load(0, 0, 3);
    check_time("load3", 0, 0, 3);
    check("load3.running", int'(running), 0);
    do_start();
    check("run3.running", int'(running), 1);
    for (int k = 2; k >= 0; k--) begin
      for (int c = 0; c < 3; c++) begin
        step();
        check("run3.hold.sec", int'(sec), k + 1);
        check("run3.hold.done", int'(done), 0);
      end
      step();
      check("run3.tick.sec", int'(sec), k);
    end
    check("exp.done", int'(done), 1);
    check("exp.running", int'(running), 0);
    step();
    check("exp.done_clear", int'(done), 0);
    check_time("exp.hold", 0, 0, 0);
    // start with time zero is ignored
    do_start();
    check("zero_start.running", int'(running), 0);
    check("zero_start.done", int'(done), 0);

    // Borrow chain through hours
    do_load(1, 0, 0);
    do_start();
    for (int c = 0; c < 3; c++) step();
    check_time("borrow_hr.pre", 1, 0, 0);
    step();
    check_time("borrow_hr", 0, 59, 59);
    check("borrow_hr.running", int'(running), 1);

    // Load during RUN returns to IDLE; borrow through minutes
    do_load(0, 1, 0);
    check("load_in_run.running", int'(running), 0);
    check_time("load_in_run", 0, 1, 0);
    do_start();
    for (int c = 0; c < 4; c++) step();
    check_time("borrow_min", 0, 0, 59);

    // Pause keeps the partial second
    do_load(0, 0, 10);
    do_start();
    for (int c = 0; c < 5; c++) step();
    check("pause.pre_sec", int'(sec), 9);
    do_stop();
    check("pause.running", int'(running), 0);
    check("pause.sec", int'(sec), 9);
    for (int c = 0; c < 20; c++) step();
    check("pause.hold_sec", int'(sec), 9);
    check("pause.hold_running", int'(running), 0);
    do_start();
    check("resume.running", int'(running), 1);
    step();
    check("resume.c1_sec", int'(sec), 9);
    step();
    check("resume.c2_sec", int'(sec), 8);

    // Out-of-range loads while paused
    do_stop();
    check("err.pause_running", int'(running), 0);
    do_load(24, 0, 0);
    check("err_hr.load_err", int'(load_err), 1);
    check_time("err_hr", 0, 0, 8);
    check("err_hr.running", int'(running), 0);
    step();
    check("err_hr.pulse_end", int'(load_err), 0);
    do_load(0, 60, 0);
    check("err_min.load_err", int'(load_err), 1);
    check_time("err_min", 0, 0, 8);
    step();
    check("err_min.pulse_end", int'(load_err), 0);
    do_load(0, 0, 60);
    check("err_sec.load_err", int'(load_err), 1);
    check_time("err_sec", 0, 0, 8);
    check("err_sec.running", int'(running), 0);
    step();
    check("err_sec.pulse_end", int'(load_err), 0);

    // Start+stop together from IDLE: stop wins
    do_load(0, 0, 5);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop.running", int'(running), 0);
    step();
    check("startstop.sec", int'(sec), 5);

    // Load+start together: load wins
    start = 1'b1;
    do_load(0, 0, 7);
    start = 1'b0;
    check("loadstart.running", int'(running), 0);
    check_time("loadstart", 0, 0, 7);
    step();
    check("loadstart.idle_sec", int'(sec), 7);

    // Reset mid-count
    do_load(0, 0, 5);
    do_start();
    for (int c = 0; c < 5; c++) step();
    check("prerst.sec", int'(sec), 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_time("midrst", 0, 0, 0);
    check("midrst.running", int'(running), 0);
    check("midrst.done", int'(done), 0);
    step();
    check("postrst.done", int'(done), 0);
    check("postrst.running", int'(running), 0);
    do_start();
    check("postrst.start_ignored", int'(running), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
